alu_sequencer: RTL and testbench

//  Initiator side of the ALU start/done handshake: accepts one ALU request at a time from the

---
 rtl/alu_sequencer_pkg.sv | 32 +++
 rtl/alu_sequencer_if.sv | 43 ++++
 rtl/alu_sequencer_timer.sv | 30 +++
 rtl/alu_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: ALU opcodes, architectural flag layout and sequencer states
package alu_sequencer_pkg;

    localparam logic [7:0] CLR_CMP_INS  = 8'h40;
    localparam logic [7:0] CMP_OFF_INS  = 8'h41;
    localparam logic [7:0] CMP_ON_INS   = 8'h42;
    localparam logic [7:0] SIGN_OFF_INS = 8'h43;
    localparam logic [7:0] SIGN_ON_INS  = 8'h44;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
        logic c;
    } flags_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_CAPTURE,
        S_MODE,
        S_MODE_SETTLE,
        S_RESPOND
    } seq_state_e;

    function automatic logic is_mode_op(input logic [7:0] op);
        return op inside {CMP_OFF_INS, CMP_ON_INS, SIGN_OFF_INS, SIGN_ON_INS};
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request, ALU start/done and response channels of the sequencer
interface alu_sequencer_if;

    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       alu_start;
    logic [7:0] alu_cins;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_oe;
    logic       alu_carryin;
    logic       alu_done;
    logic [7:0] alu_result;
    logic       alu_carryout;
    logic       alu_overout;
    logic       alu_cmpo;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_err;

    modport master (
        input  req_valid, req_op, req_a, req_b,
        input  alu_done, alu_result, alu_carryout, alu_overout, alu_cmpo,
        input  rsp_ready,
        output req_ready,
        output alu_start, alu_cins, alu_a, alu_b, alu_oe, alu_carryin,
        output rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        output req_valid, req_op, req_a, req_b,
        output alu_done, alu_result, alu_carryout, alu_overout, alu_cmpo,
        output rsp_ready,
        input  req_ready,
        input  alu_start, alu_cins, alu_a, alu_b, alu_oe, alu_carryin,
        input  rsp_valid, rsp_result, rsp_err
    );

endinterface

// File: rtl/alu_sequencer_timer.sv
// alu_sequencer_timer: abort timer for ALU waits, only built with ALU_SEQ_TIMEOUT_EN
`ifdef ALU_SEQ_TIMEOUT_EN
module alu_sequencer_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_expire
);

    localparam int unsigned W = ($clog2(TIMEOUT_CYCLES + 1) > 6) ? $clog2(TIMEOUT_CYCLES + 1) : 6;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= '0;
        else if (i_run)
            r_cnt <= r_cnt + 1'b1;
    end

    // fires on the last allowed wait cycle so the FSM leaves on the next edge
    assign o_expire = i_run && (r_cnt == W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/alu_sequencer.sv
// alu_sequencer: ALU start/done initiator with request/response handshakes and CPU flag register
// Defining ALU_SEQ_TIMEOUT_EN adds an abort timer on the ALU wait states.
module alu_sequencer
    import alu_sequencer_pkg::*;
`ifdef ALU_SEQ_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 32
)
`endif
(
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.master bus,
    output flags_t          flags
);

    seq_state_e r_state;
    seq_state_e w_next;
    logic [7:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_result;
    logic       r_err;
    logic       r_cmp_seen;
    flags_t     r_flags;
    flags_t     w_cmp_flags;
    logic       w_accept;
    logic       w_expire;
    logic       w_alu_active;

`ifdef ALU_SEQ_TIMEOUT_EN
    logic w_run;

    assign w_run = r_state inside {S_WAIT_ACK, S_WAIT_DONE, S_MODE_SETTLE};

    alu_sequencer_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (!w_run),
        .i_run   (w_run),
        .o_expire(w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        w_next = !bus.req_valid ? S_IDLE : is_mode_op(bus.req_op) ? S_MODE : S_ISSUE;
            S_ISSUE:       w_next = S_WAIT_ACK;
            S_WAIT_ACK:    w_next = w_expire ? S_RESPOND : !bus.alu_done ? S_WAIT_DONE : S_WAIT_ACK;
            S_WAIT_DONE:   w_next = w_expire ? S_RESPOND : bus.alu_done ? S_CAPTURE : S_WAIT_DONE;
            S_CAPTURE:     w_next = S_RESPOND;
            S_MODE:        w_next = S_MODE_SETTLE;
            S_MODE_SETTLE: w_next = (w_expire || bus.alu_done) ? S_RESPOND : S_MODE_SETTLE;
            S_RESPOND:     w_next = bus.rsp_ready ? S_IDLE : S_RESPOND;
            default:       w_next = S_IDLE;
        endcase
    end

    // a compare-clear instruction wipes the flags instead of loading them
    assign w_cmp_flags = (r_op == CLR_CMP_INS) ? '0 :
        flags_t'{bus.alu_result[7], bus.alu_overout, bus.alu_result == 8'h00, bus.alu_carryout};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
            r_flags    <= '0;
            r_cmp_seen <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= bus.req_op;
                r_a      <= bus.req_a;
                r_b      <= bus.req_b;
                r_result <= '0;
                r_err    <= 1'b0;
            end
            if (r_state == S_WAIT_DONE)
                r_cmp_seen <= r_cmp_seen | bus.alu_cmpo;
            if (r_state == S_CAPTURE) begin
                r_result <= bus.alu_result;
                if (r_cmp_seen)
                    r_flags <= w_cmp_flags;
            end
            if (w_expire)
                r_err <= 1'b1;
            if (r_state == S_RESPOND && bus.rsp_ready)
                r_cmp_seen <= 1'b0;
        end
    end

    assign w_alu_active    = r_state inside {S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_CAPTURE, S_MODE};
    assign bus.req_ready   = r_state == S_IDLE;
    assign bus.alu_start   = r_state == S_ISSUE;
    assign bus.alu_cins    = w_alu_active ? r_op : 8'h00;
    assign bus.alu_a       = r_a;
    assign bus.alu_b       = r_b;
    assign bus.alu_oe      = r_state inside {S_WAIT_DONE, S_CAPTURE};
    assign bus.alu_carryin = r_flags.c;
    assign bus.rsp_valid   = r_state == S_RESPOND;
    assign bus.rsp_result  = r_result;
    assign bus.rsp_err     = r_err;
    assign flags           = r_flags;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random and directed requests against an ALU stub and a transaction-level flag model
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] flags;
    int         total = 0;
    int         bad = 0;
    logic [3:0] m_flags = 4'h0;
    logic       m_cmp = 1'b0;
    logic       alu_dead = 1'b0;
    int         busy;
    logic       alu_cmp_on;

    alu_sequencer_if bus();

    alu_sequencer dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] alu_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [8:0] s;
        logic ov;
        s  = (op == 8'h01) ? {1'b0, a} + {1'b0, b} :
             (op == 8'h02) ? {1'b0, a} + {1'b0, b} + {8'd0, cin} :
             (op == 8'h03) ? {1'b0, a} - {1'b0, b} : {1'b0, a & b};
        ov = (op == 8'h01 || op == 8'h02) ? (a[7] == b[7] && s[7] != a[7]) :
             (op == 8'h03) ? (a[7] != b[7] && s[7] != a[7]) : 1'b0;
        return {s[8], ov, s[7:0]};
    endfunction

    // ALU stub: acks start one cycle later, pulses cmpo the cycle before done rises
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_done     <= 1'b1;
            bus.alu_result   <= 8'h00;
            bus.alu_carryout <= 1'b0;
            bus.alu_overout  <= 1'b0;
            bus.alu_cmpo     <= 1'b0;
            busy             <= 0;
            alu_cmp_on       <= 1'b0;
        end else begin
            bus.alu_cmpo <= 1'b0;
            if (busy == 1) begin
                bus.alu_done <= 1'b1;
                busy         <= 0;
            end else if (busy > 1) begin
                busy <= busy - 1;
                if (busy == 2 && alu_cmp_on)
                    bus.alu_cmpo <= 1'b1;
            end else if (!alu_dead && bus.alu_start) begin
                bus.alu_done <= 1'b0;
                busy         <= 7;
                {bus.alu_carryout, bus.alu_overout, bus.alu_result} <= alu_fn(bus.alu_cins, bus.alu_a, bus.alu_b, bus.alu_carryin);
            end else if (!alu_dead && bus.alu_cins inside {8'h41, 8'h42, 8'h43, 8'h44}) begin
                bus.alu_done <= 1'b0;
                busy         <= 1;
                if (bus.alu_cins == 8'h41)
                    alu_cmp_on <= 1'b0;
                if (bus.alu_cins == 8'h42)
                    alu_cmp_on <= 1'b1;
            end
        end
    end

    task automatic run_txn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input int hold, input bit to);
        logic [7:0] e_res;
        logic [3:0] e_flags;
        logic       e_c;
        logic       e_v;
        bit         mode;
        int         e_lat;
        int         lat;
        int         starts;
        int         r;
        int         sr;
        mode    = op inside {8'h41, 8'h42, 8'h43, 8'h44};
        e_flags = m_flags;
        e_res   = 8'h00;
        if (mode) begin
            e_lat = 3;
            if (op == 8'h41)
                m_cmp = 1'b0;
            if (op == 8'h42)
                m_cmp = 1'b1;
        end else if (to) begin
            e_lat = 33;
        end else begin
            e_lat = 10;
            r  = int'(a & b);
            sr = 0;
            if (op == 8'h01) begin
                r  = int'(a) + int'(b);
                sr = int'($signed(a)) + int'($signed(b));
            end else if (op == 8'h02) begin
                r  = int'(a) + int'(b) + int'(m_flags[0]);
                sr = int'($signed(a)) + int'($signed(b)) + int'(m_flags[0]);
            end else if (op == 8'h03) begin
                r  = int'(a) - int'(b);
                sr = int'($signed(a)) - int'($signed(b));
            end
            e_res = r[7:0];
            e_c   = (op == 8'h03) ? (r < 0) : (r > 255);
            e_v   = (sr < -128) || (sr > 127);
            if (m_cmp)
                e_flags = (op == 8'h40) ? 4'h0 : {e_res[7], e_v, e_res == 8'h00, e_c};
        end
        m_flags = e_flags;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        check("req_ready", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = 8'($urandom);
        lat    = 0;
        starts = 0;
        while (!bus.rsp_valid && lat < 60) begin
            starts += int'(bus.alu_start);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, e_lat);
        check("start_pulses", starts, mode ? 0 : 1);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_result", bus.rsp_result, e_res);
            check("hold_req_ready", bus.req_ready, 0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        check("rsp_result", bus.rsp_result, e_res);
        check("rsp_err", bus.rsp_err, to);
        check("flags", flags, e_flags);
        check("carryin", bus.alu_carryin, e_flags[0]);
        if (mode)
            check("mode_done_high", bus.alu_done, 1);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_once", bus.rsp_valid, 0);
        check("back_idle", bus.req_ready, 1);
    endtask

    initial begin
        logic [7:0] ops [8];
        logic [7:0] op;
        bit         seen;
        ops = '{8'h01, 8'h02, 8'h03, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 8'h00;
        bus.req_a     = 8'h00;
        bus.req_b     = 8'h00;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("reset_outputs", {bus.req_ready, bus.alu_start, bus.alu_cins, bus.alu_a, bus.alu_b, bus.alu_oe,
                                bus.rsp_valid, bus.rsp_result, bus.rsp_err, flags}, {1'b1, 40'd0});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", {bus.req_ready, bus.alu_start, bus.alu_cins, bus.rsp_valid, flags}, {1'b1, 14'd0});

        run_txn(8'h42, 8'h00, 8'h00, 0, 0);
        run_txn(8'h01, 8'h7F, 8'h01, 0, 0);
        check("add_7f_01_flags", flags, 4'hC);
        run_txn(8'h03, 8'h10, 8'h20, 5, 0);
        run_txn(8'h01, 8'h80, 8'h80, 0, 0);
        check("add_80_80_flags", flags, 4'h7);
        run_txn(8'h40, 8'h5A, 8'hA5, 0, 0);
        check("clr_cmp_flags", flags, 4'h0);
        run_txn(8'h01, 8'hFF, 8'h01, 0, 0);
        run_txn(8'h41, 8'h00, 8'h00, 0, 0);
        run_txn(8'h01, 8'h7F, 8'h01, 0, 0);
        check("cmp_off_flags_hold", flags, 4'h3);
        run_txn(8'h44, 8'h00, 8'h00, 2, 0);
        run_txn(8'h43, 8'h00, 8'h00, 0, 0);

        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ops[$urandom_range(0, 7)];
            run_txn(op, 8'($urandom), 8'($urandom), $urandom_range(0, 3), 0);
        end

        run_txn(8'h42, 8'h00, 8'h00, 0, 0);
        run_txn(8'h01, 8'hC0, 8'hC0, 0, 0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 8'h01;
        bus.req_a     = 8'h12;
        bus.req_b     = 8'h34;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midop_oe", bus.alu_oe, 1);
        #2 rst = 1'b1;
        #1;
        check("midop_reset_outputs", {bus.req_ready, bus.alu_start, bus.alu_cins, bus.alu_a, bus.alu_b, bus.alu_oe,
                                      bus.rsp_valid, bus.rsp_result, bus.rsp_err, flags}, {1'b1, 40'd0});
        @(negedge clk);
        rst     = 1'b0;
        m_flags = 4'h0;
        m_cmp   = 1'b0;
        seen    = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen |= bus.rsp_valid;
        end
        check("midop_no_response", seen, 0);
        run_txn(8'h01, 8'h01, 8'h02, 0, 0);

`ifdef ALU_SEQ_TIMEOUT_EN
        alu_dead = 1'b1;
        run_txn(8'h01, 8'h22, 8'h33, 0, 1);
        alu_dead = 1'b0;
        run_txn(8'h02, 8'h01, 8'h01, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
